// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: write/status/launch signals between the register front end, the TX FIFO and uart_tx
interface uart_tx_fifo_if #(parameter int PTR_W = 4);
  logic             wr_en;
  logic [7:0]       wr_data;
  logic             flush;
  logic             ovf_clr;
  logic [PTR_W:0]   count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic [7:0]       tx_data;
  logic             tx_start;
  logic             tx_busy;
  modport master (
    output wr_en, wr_data, flush, ovf_clr, tx_busy,
    input  count, empty, full, overflow, tx_data, tx_start
  );
  modport slave (
    input  wr_en, wr_data, flush, ovf_clr, tx_busy,
    output count, empty, full, overflow, tx_data, tx_start
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of uart_tx, drained by a tx_start/tx_busy launch FSM
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input logic           clk,
  input logic           rst_n,
  uart_tx_fifo_if.slave fifo_if
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;
  state_t           state_q, state_d;
  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             ovf_q, ovf_d, tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             empty, full, push, pop, drop;
  assign empty = count_q == '0;
  assign full  = count_q == (PTR_W+1)'(DEPTH);
  assign push  = fifo_if.wr_en && !full && !fifo_if.flush;
  assign drop  = fifo_if.wr_en && full && !fifo_if.flush;
  // head leaves only once uart_tx has acknowledged it with tx_busy
  assign pop   = state_q == LAUNCH && fifo_if.tx_busy && !fifo_if.flush;
  always_comb begin
    wr_ptr_d = fifo_if.flush ? '0 : wr_ptr_q + PTR_W'(push);
    rd_ptr_d = fifo_if.flush ? '0 : rd_ptr_q + PTR_W'(pop);
    count_d  = fifo_if.flush ? '0 : count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    ovf_d    = drop ? 1'b1 : (fifo_if.ovf_clr || fifo_if.flush) ? 1'b0 : ovf_q;
  end
  always_comb begin
    state_d    = state_q;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    case (state_q)
      IDLE: if (!empty && !fifo_if.tx_busy && !fifo_if.flush) begin
        state_d    = LAUNCH;
        tx_start_d = 1'b1;
        tx_data_d  = mem_q[rd_ptr_q];
      end
      LAUNCH: if (fifo_if.tx_busy || fifo_if.flush) begin
        state_d    = WAIT_DONE;
        tx_start_d = 1'b0;
      end
      WAIT_DONE: state_d = fifo_if.tx_busy ? WAIT_DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= fifo_if.wr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  assign fifo_if.count    = count_q;
  assign fifo_if.empty    = empty;
  assign fifo_if.full     = full;
  assign fifo_if.overflow = ovf_q;
  assign fifo_if.tx_start = tx_start_q;
  assign fifo_if.tx_data  = tx_data_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: queue-based model of the FIFO plus a uart_tx responder, random and directed stimulus
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int PTR_W = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  uart_tx_fifo_if #(.PTR_W(PTR_W)) bus ();
  uart_tx_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (.clk(clk), .rst_n(rst_n), .fifo_if(bus));
  int checks = 0;
  int errors = 0;
  logic [7:0] mq[$];
  logic [7:0] rx_log[$];
  logic m_ovf = 1'b0;
  bit pend = 1'b0;
  bit hold = 1'b0;
  int flen = 4;
  int bcnt = 0;
  logic busy_nx = 1'b0;
  logic busy_edge = 1'b0;
  logic st_prev = 1'b0;
  logic [7:0] td_prev = 8'h00;
  bit full_pre, popv, mby, mst;
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  // reference: FIFO contents as a queue; uart_tx as a busy counter
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
      pend = 1'b0;
      busy_nx = 1'b0;
      bcnt = 0;
    end else begin
      mby = busy_nx;
      mst = bus.tx_start;
      busy_edge = mby;
      full_pre = mq.size() == DEPTH;
      if (mst && !mby && !hold) begin
        chk("capture_nonempty", int'(mq.size() != 0), 1);
        if (mq.size() != 0) chk("capture_byte", bus.tx_data, mq[0]);
        chk("capture_dup", int'(pend), 0);
        pend = 1'b1;
        rx_log.push_back(bus.tx_data);
        busy_nx = 1'b1;
        bcnt = flen;
      end else if (mby) begin
        bcnt--;
        if (bcnt <= 0) busy_nx = 1'b0;
      end
      popv = mst && mby && !bus.flush;
      if (popv) begin
        chk("pop_nonempty", int'(mq.size() != 0), 1);
        if (mq.size() != 0) void'(mq.pop_front());
        pend = 1'b0;
      end
      if (bus.flush) begin
        mq.delete();
        m_ovf = 1'b0;
        pend = 1'b0;
      end else if (bus.wr_en && full_pre) m_ovf = 1'b1;
      else begin
        if (bus.wr_en) mq.push_back(bus.wr_data);
        if (bus.ovf_clr) m_ovf = 1'b0;
      end
    end
  end
  initial forever begin
    @(negedge clk or negedge rst_n);
    bus.tx_busy = rst_n ? busy_nx : 1'b0;
  end
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("count", bus.count, mq.size());
      chk("empty", bus.empty, int'(mq.size() == 0));
      chk("full", bus.full, int'(mq.size() == DEPTH));
      chk("overflow", bus.overflow, m_ovf);
      if (bus.tx_start && !st_prev) chk("start_while_busy", busy_edge, 0);
      if (bus.tx_start && st_prev) chk("tx_data_hold", bus.tx_data, td_prev);
      st_prev = bus.tx_start;
      td_prev = bus.tx_data;
    end else st_prev = 1'b0;
  end
  initial begin
    #900000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  task automatic drain(input string n);
    int k = 0;
    hold = 1'b0;
    while ((mq.size() != 0 || busy_nx || bus.tx_start) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk(n, int'(k < 5000), 1);
  endtask
  task automatic wr(input logic [7:0] d);
    @(negedge clk);
    bus.wr_en = 1'b1;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask
  initial begin
    int base;
    logic [7:0] exp_b[$];
    bus.wr_en = 0; bus.wr_data = 0; bus.flush = 0; bus.ovf_clr = 0;
    repeat (3) @(negedge clk);
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_start", bus.tx_start, 0);
    chk("rst_data", bus.tx_data, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    // single byte: latency E0..E3
    bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
    @(negedge clk);
    bus.wr_en = 1'b0;
    chk("sb_e0_empty", bus.empty, 0);
    chk("sb_e0_count", bus.count, 1);
    chk("sb_e0_start", bus.tx_start, 0);
    @(negedge clk);
    chk("sb_e1_start", bus.tx_start, 1);
    chk("sb_e1_data", bus.tx_data, 8'hA5);
    @(negedge clk);
    chk("sb_e2_start", bus.tx_start, 1);
    chk("sb_e2_count", bus.count, 1);
    @(negedge clk);
    chk("sb_e3_start", bus.tx_start, 0);
    chk("sb_e3_count", bus.count, 0);
    drain("sb_drain");
    chk("sb_rx", rx_log[rx_log.size()-1], 8'hA5);
    // burst of 16 then an overflowing 17th with uart_tx held off
    hold = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      if (i == 17) chk("burst_full", bus.full, 1);
      bus.wr_en = 1'b1; bus.wr_data = 8'(i);
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
    chk("burst_ovf", bus.overflow, 1);
    chk("burst_count", bus.count, 16);
    base = rx_log.size();
    drain("burst_drain");
    chk("burst_nrx", rx_log.size() - base, 16);
    for (int i = 0; i < 16 && base + i < rx_log.size(); i++) chk("burst_order", rx_log[base+i], i + 1);
    chk("burst_empty", bus.empty, 1);
    chk("burst_ovf_sticky", bus.overflow, 1);
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
    chk("ovf_clr", bus.overflow, 0);
    // push on the pop edge keeps count at 3
    hold = 1'b1;
    for (int i = 0; i < 3; i++) wr(8'(8'h31 + i));
    chk("cc_count3", bus.count, 3);
    chk("cc_launch", bus.tx_start, 1);
    hold = 1'b0;
    base = rx_log.size();
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_data = 8'h44;
    @(negedge clk);
    bus.wr_en = 1'b0;
    chk("cc_count_kept", bus.count, 3);
    chk("cc_start_low", bus.tx_start, 0);
    drain("cc_drain");
    exp_b = '{8'h31, 8'h32, 8'h33, 8'h44};
    chk("cc_nrx", rx_log.size() - base, 4);
    for (int i = 0; i < 4 && base + i < rx_log.size(); i++) chk("cc_order", rx_log[base+i], exp_b[i]);
    // pointer wrap: 20 bytes in groups of 5
    base = rx_log.size();
    exp_b.delete();
    for (int g = 0; g < 4; g++) begin
      flen = $urandom_range(2, 9);
      for (int i = 0; i < 5; i++) begin
        exp_b.push_back(8'($urandom));
        wr(exp_b[exp_b.size()-1]);
      end
      drain("wrap_drain");
    end
    chk("wrap_nrx", rx_log.size() - base, 20);
    for (int i = 0; i < 20 && base + i < rx_log.size(); i++) chk("wrap_order", rx_log[base+i], exp_b[i]);
    // flush during LAUNCH with 4 queued
    hold = 1'b1;
    for (int i = 0; i < 4; i++) wr(8'(8'h51 + i));
    chk("fl_launch", bus.tx_start, 1);
    chk("fl_count4", bus.count, 4);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("fl_start_low", bus.tx_start, 0);
    chk("fl_count0", bus.count, 0);
    base = rx_log.size();
    hold = 1'b0;
    repeat (30) @(negedge clk);
    chk("fl_no_frames", rx_log.size() - base, 0);
    // flush coincident with a write into a full FIFO
    hold = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'h60 + i);
    end
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_data = 8'h99; bus.flush = 1'b1;
    chk("flw_full", bus.full, 1);
    @(negedge clk);
    bus.wr_en = 1'b0; bus.flush = 1'b0;
    chk("flw_count", bus.count, 0);
    chk("flw_ovf", bus.overflow, 0);
    drain("flw_drain");
    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      bus.wr_en = ($urandom % 3) == 0;
      bus.wr_data = 8'($urandom);
      bus.flush = ($urandom % 80) == 0;
      bus.ovf_clr = ($urandom % 20) == 0;
      hold = ($urandom % 4) == 0;
      if ($urandom % 16 == 0) flen = $urandom_range(1, 12);
    end
    @(negedge clk);
    bus.wr_en = 0; bus.flush = 0; bus.ovf_clr = 0;
    drain("rand_drain");
    // asynchronous reset while a frame is in flight
    flen = 40;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'h70 + i);
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    chk("mr_count5", bus.count, 5);
    chk("mr_wait_done", bus.tx_start, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_count", bus.count, 0);
    chk("mr_empty", bus.empty, 1);
    chk("mr_full", bus.full, 0);
    chk("mr_ovf", bus.overflow, 0);
    chk("mr_start", bus.tx_start, 0);
    chk("mr_data", bus.tx_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    flen = 4;
    repeat (20) begin
      @(negedge clk);
      chk("mr_no_start", bus.tx_start, 0);
    end
    wr(8'h5A);
    drain("mr_after");
    chk("mr_rx", rx_log[rx_log.size()-1], 8'h5A);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
